// File: rtl/uart_transceiver_pkg.sv
// uart_transceiver_pkg: shared frame type, FSM state types and parity helper
package uart_transceiver_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int PRESCALE_W = 6;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef logic [DATA_WIDTH-1:0] dataframe_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic logic parity_bit(input dataframe_t d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_transceiver_if.sv
// uart_transceiver_if: system-side and serial-pin signals of the UART
interface uart_transceiver_if;
  import uart_transceiver_pkg::*;
  dataframe_t TX_P_DATA;
  logic TX_DATA_VALID;
  logic PAR_EN;
  logic PAR_TYP;
  logic [PRESCALE_W-1:0] prescale;
  logic RX_IN;
  logic TX_OUT;
  logic Busy;
  dataframe_t RX_P_DATA;
  logic RX_DATA_VALID;
  logic PARITY_ERROR;
  logic FRAME_ERROR;
  modport master(output TX_P_DATA, TX_DATA_VALID, PAR_EN, PAR_TYP, prescale, RX_IN,
                 input TX_OUT, Busy, RX_P_DATA, RX_DATA_VALID, PARITY_ERROR, FRAME_ERROR);
  modport slave(input TX_P_DATA, TX_DATA_VALID, PAR_EN, PAR_TYP, prescale, RX_IN,
                output TX_OUT, Busy, RX_P_DATA, RX_DATA_VALID, PARITY_ERROR, FRAME_ERROR);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronises, oversamples and checks incoming serial frames
module uart_rx_core import uart_transceiver_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output dataframe_t            rx_data,
  output logic                  rx_valid,
  output logic                  par_err,
  output logic                  frm_err
);
  rx_state_t state_q, state_d;
  logic [2:0] sync_q, sync_d, bit_q, bit_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d, half;
  logic [1:0] smp_q, smp_d;
  dataframe_t shift_q, shift_d, data_q, data_d;
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, par_q, par_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic rx, fall, bit_end, vote, maj;
  always_comb begin
    sync_d = {sync_q[1:0], rx_in};
    rx = sync_q[1];
    fall = sync_q[2] & ~sync_q[1];
    half = prescale >> 1;
    bit_end = cnt_q == prescale - PRESCALE_W'(1);
    vote = cnt_q == half + PRESCALE_W'(1);
    maj = (smp_q[0] & smp_q[1]) | (rx & (smp_q[0] | smp_q[1]));
    smp_d = {cnt_q == half ? rx : smp_q[1], cnt_q == half - PRESCALE_W'(1) ? rx : smp_q[0]};
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    par_en_d = par_en_q;
    par_typ_d = par_typ_q;
    par_d = par_q;
    valid_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      RX_IDLE: if (fall) begin
        state_d = RX_START;
        par_en_d = par_en;
        par_typ_d = par_typ;
      end
      RX_START: begin
        if (vote && maj) state_d = RX_IDLE;
        else if (bit_end) begin
          state_d = RX_DATA;
          bit_d = '0;
        end
      end
      RX_DATA: begin
        if (vote) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = par_en_q ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (vote) par_d = maj;
        if (bit_end) state_d = RX_STOP;
      end
      RX_STOP: if (vote) begin
        state_d = RX_IDLE;
        ferr_d = ~maj;
        perr_d = maj & par_en_q & (par_q != parity_bit(shift_q, par_typ_q));
        valid_d = maj & ~perr_d;
        data_d = valid_d ? shift_q : data_q;
      end
      default: state_d = RX_IDLE;
    endcase
    // the falling-edge cycle is count 0 of the start bit
    cnt_d = state_q == RX_IDLE ? PRESCALE_W'(fall) :
            (state_d == RX_IDLE || bit_end) ? '0 : cnt_q + PRESCALE_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync_q <= '1;
      bit_q <= '0;
      cnt_q <= '0;
      smp_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      par_q <= 1'b0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      smp_q <= smp_d;
      shift_q <= shift_d;
      data_q <= data_d;
      par_en_q <= par_en_d;
      par_typ_q <= par_typ_d;
      par_q <= par_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end
  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign par_err = perr_q;
  assign frm_err = ferr_q;
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: serialises one byte per request with optional parity
module uart_tx_core import uart_transceiver_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  dataframe_t            data,
  input  logic                  valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);
  tx_state_t state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  dataframe_t shift_q, shift_d;
  logic par_en_q, par_en_d, par_q, par_d, tx_out_q, tx_out_d, bit_end;
  always_comb begin
    bit_end = cnt_q == prescale - PRESCALE_W'(1);
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_en_d = par_en_q;
    par_d = par_q;
    case (state_q)
      TX_IDLE: if (valid) begin
        state_d = TX_START;
        shift_d = data;
        par_en_d = par_en;
        par_d = parity_bit(data, par_typ);
      end
      TX_START: if (bit_end) begin
        state_d = TX_DATA;
        bit_d = '0;
      end
      TX_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = par_en_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (bit_end) state_d = TX_STOP;
      TX_STOP: if (bit_end) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
    cnt_d = (state_q == TX_IDLE || bit_end) ? '0 : cnt_q + PRESCALE_W'(1);
    // registered line value is derived from the state being entered
    tx_out_d = state_d == TX_START  ? 1'b0 :
               state_d == TX_DATA   ? shift_d[0] :
               state_d == TX_PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      tx_out_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_en_q <= par_en_d;
      par_q <= par_d;
      tx_out_q <= tx_out_d;
    end
  end
  assign tx_out = tx_out_q;
  assign busy = state_q != TX_IDLE;
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART wiring the transmit and receive cores
module uart_transceiver (
  input logic                CLK,
  input logic                RST,
  uart_transceiver_if.slave  bus
);
  uart_tx_core u_tx (
    .clk(CLK), .rst(RST), .data(bus.TX_P_DATA), .valid(bus.TX_DATA_VALID),
    .par_en(bus.PAR_EN), .par_typ(bus.PAR_TYP), .prescale(bus.prescale),
    .tx_out(bus.TX_OUT), .busy(bus.Busy)
  );
  uart_rx_core u_rx (
    .clk(CLK), .rst(RST), .rx_in(bus.RX_IN), .par_en(bus.PAR_EN), .par_typ(bus.PAR_TYP),
    .prescale(bus.prescale), .rx_data(bus.RX_P_DATA), .rx_valid(bus.RX_DATA_VALID),
    .par_err(bus.PARITY_ERROR), .frm_err(bus.FRAME_ERROR)
  );
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed loopback and direct-drive checks of the UART
module tb_uart_transceiver;
  import uart_transceiver_pkg::*;
  logic clk = 1'b0, rst = 1'b1, loop = 1'b1, rx_drv = 1'b1;
  int checks = 0, errors = 0;
  int nvalid = 0, nperr = 0, nferr = 0;
  int v0, p0, f0, bc, base;
  logic [10:0] seq;
  logic [7:0] rxq[$];
  uart_transceiver_if bus();
  uart_transceiver dut (.CLK(clk), .RST(rst), .bus(bus));
  assign bus.RX_IN = loop ? bus.TX_OUT : rx_drv;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.RX_DATA_VALID) begin
      nvalid++;
      rxq.push_back(bus.RX_P_DATA);
    end
    if (bus.PARITY_ERROR) nperr++;
    if (bus.FRAME_ERROR) nferr++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    v0 = nvalid;
    p0 = nperr;
    f0 = nferr;
  endtask
  task automatic send_frame(input logic [7:0] d, output logic [10:0] s, output int b);
    s = '0;
    b = 0;
    bus.TX_P_DATA = d;
    bus.TX_DATA_VALID = 1'b1;
    @(negedge clk);
    bus.TX_DATA_VALID = 1'b0;
    for (int i = 0; i < 400 && bus.Busy; i++) begin
      if (i % 16 == 8 && i / 16 < 11) s[i/16] = bus.TX_OUT;
      b++;
      @(negedge clk);
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 500 && bus.Busy; i++) @(negedge clk);
    check("tx_idle", bus.Busy, 0);
  endtask
  task automatic drive_frame(input logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
  endtask
  initial begin
    bus.TX_P_DATA = '0;
    bus.TX_DATA_VALID = 1'b0;
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = PAR_EVEN;
    bus.prescale = 6'd16;
    repeat (3) @(negedge clk);
    check("rst_tx_out", bus.TX_OUT, 1);
    check("rst_busy", bus.Busy, 0);
    check("rst_rx_data", bus.RX_P_DATA, 0);
    check("rst_rx_valid", bus.RX_DATA_VALID, 0);
    check("rst_perr", bus.PARITY_ERROR, 0);
    check("rst_ferr", bus.FRAME_ERROR, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    snap();
    send_frame(8'h55, seq, bc);
    repeat (5) @(negedge clk);
    check("t1_seq", seq, 11'b10010101010);
    check("t1_busy", bc, 176);
    check("t1_valid", nvalid - v0, 1);
    check("t1_data", bus.RX_P_DATA, 8'h55);
    check("t1_perr", nperr - p0, 0);
    check("t1_ferr", nferr - f0, 0);
    snap();
    base = rxq.size();
    bus.TX_P_DATA = 8'hA3;
    bus.TX_DATA_VALID = 1'b1;
    @(negedge clk);
    bus.TX_DATA_VALID = 1'b0;
    repeat (40) @(negedge clk);
    bus.TX_P_DATA = 8'h12;
    bus.TX_DATA_VALID = 1'b1;
    @(negedge clk);
    bus.TX_DATA_VALID = 1'b0;
    wait_idle();
    send_frame(8'hFF, seq, bc);
    check("t2_par_ff", seq[9], 0);
    send_frame(8'h00, seq, bc);
    check("t2_par_00", seq[9], 0);
    repeat (5) @(negedge clk);
    check("t2_count", rxq.size() - base, 3);
    check("t2_b0", rxq[base], 8'hA3);
    check("t2_b1", rxq[base+1], 8'hFF);
    check("t2_b2", rxq[base+2], 8'h00);
    check("t2_errs", (nperr - p0) + (nferr - f0), 0);
    bus.PAR_TYP = PAR_ODD;
    snap();
    send_frame(8'h3C, seq, bc);
    repeat (5) @(negedge clk);
    check("t3_seq", seq, 11'b11001111000);
    check("t3_data", bus.RX_P_DATA, 8'h3C);
    check("t3_valid", nvalid - v0, 1);
    check("t3_perr", nperr - p0, 0);
    bus.PAR_EN = 1'b0;
    bus.TX_P_DATA = '0;
    repeat (3) @(negedge clk);
    snap();
    send_frame(8'h3C, seq, bc);
    repeat (5) @(negedge clk);
    check("t3n_busy", bc, 160);
    check("t3n_valid", nvalid - v0, 1);
    check("t3n_data", bus.RX_P_DATA, 8'h3C);
    loop = 1'b0;
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = PAR_EVEN;
    repeat (5) @(negedge clk);
    snap();
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", nvalid - v0, 0);
    check("glitch_perr", nperr - p0, 0);
    check("glitch_ferr", nferr - f0, 0);
    drive_frame(11'b10101001010);
    check("a5_valid", nvalid - v0, 1);
    check("a5_data", bus.RX_P_DATA, 8'hA5);
    snap();
    drive_frame(11'b11001111000);
    check("pe_perr", nperr - p0, 1);
    check("pe_valid", nvalid - v0, 0);
    check("pe_ferr", nferr - f0, 0);
    check("pe_hold", bus.RX_P_DATA, 8'hA5);
    snap();
    drive_frame(11'b01001111000);
    check("fe_ferr", nferr - f0, 1);
    check("fe_perr", nperr - p0, 0);
    check("fe_valid", nvalid - v0, 0);
    check("fe_hold", bus.RX_P_DATA, 8'hA5);
    loop = 1'b1;
    repeat (5) @(negedge clk);
    bus.TX_P_DATA = 8'h81;
    bus.TX_DATA_VALID = 1'b1;
    @(negedge clk);
    bus.TX_DATA_VALID = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_out", bus.TX_OUT, 1);
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_rx_data", bus.RX_P_DATA, 0);
    check("mid_rst_rx_valid", bus.RX_DATA_VALID, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    snap();
    send_frame(8'h81, seq, bc);
    repeat (5) @(negedge clk);
    check("r81_seq", seq, 11'b10100000010);
    check("r81_valid", nvalid - v0, 1);
    check("r81_data", bus.RX_P_DATA, 8'h81);
    check("r81_errs", (nperr - p0) + (nferr - f0), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
